// File: rtl/mc_alu_if.sv
// Request/response bundle for mc_alu: operand request channel in, result channel out.
interface mc_alu_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL and
// restoring DIVU, with a valid/ready request and a held valid/ready result.
module mc_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  mc_alu_if.slave  bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_is_div;
  logic [WIDTH-1:0] r_opd;
  logic [AW-1:0]    r_acc;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;

  logic             w_accept;
  logic             w_iter_op;
  logic             w_last;
  logic [AW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_dz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SW-1:0]    w_sh;
  logic [SW:0]      w_lsh;

  // One shift-add step: accumulator is {partial product high, remaining multiplier}.
  function automatic logic [AW-1:0] f_mul_step(input logic [AW-1:0]    acc,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring-division step: accumulator is {remainder, dividend/quotient}.
  function automatic logic [AW-1:0] f_div_step(input logic [AW-1:0]    acc,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    rem_sh = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - d;
    if (rem_sh >= {1'b0, d}) return {diff, acc[WIDTH-2:0], 1'b1};
    else                     return {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_iter_op  = (bus.op == OP_MUL) || ((bus.op == OP_DIVU) && (bus.b != '0));
  assign w_last     = (r_cnt == '0);
  assign w_acc_next = r_is_div ? f_div_step(r_acc, r_opd) : f_mul_step(r_acc, r_opd);

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_iter_op ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_next_state = S_DONE;
      S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

  // Single-cycle operations, evaluated on the operands presented at accept.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dz    = 1'b0;
    w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    w_sh    = bus.b[SW-1:0];
    w_lsh   = (SW+1)'(WIDTH) - {1'b0, w_sh};
    case (bus.op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      // Left part vanishes for a zero amount because the shift equals WIDTH.
      OP_ROR:  w_res = (bus.a >> w_sh) | (bus.a << w_lsh);
      OP_SHL:  w_res = bus.a << w_sh;
      OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_sh);
      OP_DIVU: begin
        if (bus.b == '0) begin
          w_res = '1;
          w_dz  = 1'b1;
        end
      end
      default: w_res = '0;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_iter_op) begin
              // The accept edge already performs the first of WIDTH iterations.
              r_is_div <= (bus.op == OP_DIVU);
              r_cnt    <= SW'(WIDTH - 2);
              if (bus.op == OP_DIVU) begin
                r_opd <= bus.b;
                r_acc <= f_div_step({{WIDTH{1'b0}}, bus.a}, bus.b);
              end else begin
                r_opd <= bus.a;
                r_acc <= f_mul_step({{WIDTH{1'b0}}, bus.b}, bus.a);
              end
            end else begin
              r_result <= w_res;
              r_flags  <= {w_dz, w_carry, w_ovf, (w_res == '0), w_res[WIDTH-1]};
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_flags  <= {1'b0,
                         (!r_is_div) && (w_acc_next[AW-1:WIDTH] != '0),
                         1'b0,
                         (w_acc_next[WIDTH-1:0] == '0),
                         w_acc_next[WIDTH-1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu at WIDTH=16.
module tb_mc_alu;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_alu_if #(.WIDTH(W)) bus ();
  mc_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic rdy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, then count edges from accept until out_valid is seen.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      rdy_seen |= bus.in_ready;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp_res,
                     input logic [4:0] exp_flags, input int exp_lat);
    issue(op, a, b);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    check({tag, "_res"},   32'(bus.result),    32'(exp_res));
    check({tag, "_flags"}, 32'(bus.flags),     32'(exp_flags));
    check({tag, "_lat"},   32'(lat),           32'(exp_lat));
    take(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_result",    32'(bus.result),    32'h0);
    check("rst_flags",     32'(bus.flags),     32'h0);
    rst = 1'b0;

    // flags = {dz, carry, overflow, zero, negative}
    run("add_ovf",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1);
    run("sub_eq",    4'd1,  16'h0005, 16'h0005, 16'h0000, 5'b01010, 1);
    run("sub_borrow",4'd1,  16'h0000, 16'h0001, 16'hFFFF, 5'b00001, 1);
    run("ror_1",     4'd7,  16'h0001, 16'h0011, 16'h8000, 5'b00001, 1);
    run("ror_0",     4'd7,  16'h1234, 16'h0000, 16'h1234, 5'b00000, 1);
    run("shl_4",     4'd8,  16'h0003, 16'h0004, 16'h0030, 5'b00000, 1);
    run("sra_3",     4'd9,  16'h8000, 16'h0003, 16'hF000, 5'b00001, 1);
    run("slt",       4'd5,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000, 1);
    run("sltu",      4'd6,  16'hFFFF, 16'h0001, 16'h0000, 5'b00010, 1);
    run("xor",       4'd4,  16'hFF00, 16'h0FF0, 16'hF0F0, 5'b00001, 1);
    run("rsvd",      4'd13, 16'h0005, 16'h0005, 16'h0000, 5'b00010, 1);

    run("mul_wrap",  4'd10, 16'h0100, 16'h0100, 16'h0000, 5'b01010, 16);
    check("mul_wrap_ready_low", 32'(rdy_seen), 32'h0);
    run("mul_3x5",   4'd10, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 16);
    run("divu_100_7",4'd11, 16'd100,  16'd7,    16'd14,   5'b00000, 16);
    check("divu_ready_low", 32'(rdy_seen), 32'h0);
    run("divu_big",  4'd11, 16'hFFFF, 16'h0010, 16'h0FFF, 5'b00000, 16);
    run("divu_zero", 4'd11, 16'd5,    16'd0,    16'hFFFF, 5'b10001, 1);

    // Result held while the consumer stalls; input activity must not disturb it.
    issue(4'd0, 16'h0002, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      bus.op = 4'd1; bus.a = 16'(i * 16'h1111); bus.b = 16'h0007; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 32'(bus.out_valid), 32'h1);
      check("stall_ready", 32'(bus.in_ready),  32'h0);
      check("stall_res",   32'(bus.result),    32'h4);
      check("stall_flags", 32'(bus.flags),     32'h0);
    end
    bus.in_valid = 1'b0;
    take("stall");
    @(posedge clk); #1;
    check("stall_no_accept", 32'(bus.out_valid), 32'h0);

    // Reset in the middle of a multiply aborts it without leaving any result.
    bus.op = 4'd10; bus.a = 16'h0003; bus.b = 16'h0005; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'h1);
    check("midrst_result",    32'(bus.result),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("post_rst_add", 4'd0, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_stale", 32'(bus.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
